window_gen_3x3: RTL and testbench

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

---
 rtl/window_gen_3x3.sv | 157 +++++++++++++++
 tb/tb_window_gen_3x3.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/window_gen_3x3.sv
// window_gen_3x3
// Streams 8-bit grayscale pixels in raster order and emits a 3x3
// neighbourhood window for every interior pixel of the frame.
// Two line buffers hold the previous two rows. A 3x3 register window
// shifts left by one column on each accepted beat.
//
// Parameters
//   IMG_WIDTH  : pixels per row   (3..4096)
//   IMG_HEIGHT : rows per frame   (3..4096)
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-high reset
//   pix_in     : pixel value
//   pix_valid  : pix_in carries a beat this cycle
//   pix_sof    : beat is row 0 / col 0 of a frame (only meaningful with pix_valid)
//   px0..px8   : window, row-major; px0 oldest row/oldest col, px8 newest pixel
//   win_valid  : px0..px8 hold a complete window (one cycle per interior beat)
module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       pix_sof,
  output logic [7:0] px0,
  output logic [7:0] px1,
  output logic [7:0] px2,
  output logic [7:0] px3,
  output logic [7:0] px4,
  output logic [7:0] px5,
  output logic [7:0] px6,
  output logic [7:0] px7,
  output logic [7:0] px8,
  output logic       win_valid
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [CW-1:0] col_cur_s;
  logic [RW-1:0] row_cur_s;
  logic [CW-1:0] col_nxt_s;
  logic [RW-1:0] row_nxt_s;
  logic          win_hit_s;

  // lb_new_r holds row-1, lb_old_r holds row-2 (relative to the current beat)
  logic [7:0] lb_new_r [IMG_WIDTH];
  logic [7:0] lb_old_r [IMG_WIDTH];
  logic [7:0] tap_new_s;
  logic [7:0] tap_old_s;

  logic [7:0] win_r [9];
  logic       win_valid_r;

  // Position of the current beat: a start-of-frame beat is always (0,0).
  always_comb begin
    col_cur_s = col_r;
    row_cur_s = row_r;
    if (pix_sof) begin
      col_cur_s = {CW{1'b0}};
      row_cur_s = {RW{1'b0}};
    end else begin
      col_cur_s = col_r;
      row_cur_s = row_r;
    end
  end

  // Counter advance with row and frame wrap.
  always_comb begin
    col_nxt_s = col_cur_s;
    row_nxt_s = row_cur_s;
    if (col_cur_s == COL_LAST) begin
      col_nxt_s = {CW{1'b0}};
      if (row_cur_s == ROW_LAST) begin
        row_nxt_s = {RW{1'b0}};
      end else begin
        row_nxt_s = row_cur_s + RW'(1);
      end
    end else begin
      col_nxt_s = col_cur_s + CW'(1);
      row_nxt_s = row_cur_s;
    end
  end

  // A window exists only once two full rows and two columns of the current
  // frame are behind the beat, which also hides stale line-buffer contents.
  always_comb begin
    win_hit_s = (row_cur_s >= RW'(2)) && (col_cur_s >= CW'(2));
  end

  // Line-buffer read taps at the current column.
  always_comb begin
    tap_new_s = lb_new_r[col_cur_s];
    tap_old_s = lb_old_r[col_cur_s];
  end

  // Position counters; frozen on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (pix_valid) begin
      col_r <= col_nxt_s;
      row_r <= row_nxt_s;
    end
  end

  // Line buffers: the new pixel enters the newer row, the displaced value
  // ages into the older row. Contents need no reset.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb_new_r[col_cur_s] <= pix_in;
      lb_old_r[col_cur_s] <= tap_new_s;
    end
  end

  // Window shift register and its valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        win_r[i] <= 8'd0;
      end
      win_valid_r <= 1'b0;
    end else if (pix_valid) begin
      win_r[0]    <= win_r[1];
      win_r[1]    <= win_r[2];
      win_r[2]    <= tap_old_s;
      win_r[3]    <= win_r[4];
      win_r[4]    <= win_r[5];
      win_r[5]    <= tap_new_s;
      win_r[6]    <= win_r[7];
      win_r[7]    <= win_r[8];
      win_r[8]    <= pix_in;
      win_valid_r <= win_hit_s;
    end else begin
      win_valid_r <= 1'b0;
    end
  end

  assign px0       = win_r[0];
  assign px1       = win_r[1];
  assign px2       = win_r[2];
  assign px3       = win_r[3];
  assign px4       = win_r[4];
  assign px5       = win_r[5];
  assign px6       = win_r[6];
  assign px7       = win_r[7];
  assign px8       = win_r[8];
  assign win_valid = win_valid_r;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 at 5x4 image size.
// The reference model keeps a frame image indexed by (row, col) and cuts
// the expected 3x3 neighbourhood directly out of it.
module tb_window_gen_3x3;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_in = 8'd0;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic [7:0] px [9];
  logic       win_valid;

  window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .px0(px[0]), .px1(px[1]), .px2(px[2]), .px3(px[3]), .px4(px[4]),
    .px5(px[5]), .px6(px[6]), .px7(px[7]), .px8(px[8]),
    .win_valid(win_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int c;
    int p[9];
  } vec_t;

  vec_t tbl[6];

  int total = 0;
  int bad = 0;
  int m_row = 0;
  int m_col = 0;
  int img[H][W];
  int win_cnt = 0;
  int cap_q[$];
  int beat_no = 0;
  int first_win_beat = -1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: model predicts, DUT consumes, outputs checked 1 ns later.
  task automatic step(input bit v, input bit s, input int p);
    int r;
    int c;
    bit ev;
    int ew[9];
    ev = 1'b0;
    for (int k = 0; k < 9; k++) ew[k] = 0;
    pix_valid = v;
    pix_sof = s;
    pix_in = p[7:0];
    if (v) begin
      if (s) begin
        r = 0;
        c = 0;
      end else begin
        r = m_row;
        c = m_col;
      end
      img[r][c] = p & 255;
      ev = (r >= 2) && (c >= 2);
      if (ev) begin
        for (int k = 0; k < 9; k++) ew[k] = img[r - 2 + k / 3][c - 2 + k % 3];
      end
      c = c + 1;
      if (c == W) begin
        c = 0;
        r = r + 1;
        if (r == H) r = 0;
      end
      m_row = r;
      m_col = c;
    end
    @(posedge clk);
    #1;
    chk("win_valid", int'(win_valid), int'(ev));
    if (ev) begin
      for (int k = 0; k < 9; k++) chk($sformatf("px%0d", k), int'(px[k]), ew[k]);
    end
    if (win_valid) begin
      win_cnt++;
      if (first_win_beat < 0) first_win_beat = beat_no;
      for (int k = 0; k < 9; k++) cap_q.push_back(int'(px[k]));
    end
    if (v) beat_no++;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  // Full frame of pixels base + 10*row + col, optional idle cycle after each beat.
  task automatic frame(input int base, input bit sof_first, input bit gaps);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b1, sof_first && (r == 0) && (c == 0), base + 10 * r + c);
        if (gaps) step(1'b0, 1'b0, 0);
      end
    end
  endtask

  // Compare six captured windows starting at window index off against the table.
  task automatic check_tbl(input int off);
    if (cap_q.size() < (off + 6) * 9) begin
      chk("captured_len", cap_q.size(), (off + 6) * 9);
    end else begin
      for (int e = 0; e < 6; e++) begin
        for (int k = 0; k < 9; k++) begin
          chk($sformatf("tbl(%0d,%0d)_px%0d", tbl[e].r, tbl[e].c, k),
              cap_q[(off + e) * 9 + k], tbl[e].p[k]);
        end
      end
    end
  endtask

  task automatic clear_stats();
    win_cnt = 0;
    cap_q.delete();
    beat_no = 0;
    first_win_beat = -1;
  endtask

  initial begin
    // Expected windows for a frame with pixel = 10*row + col.
    tbl[0].r = 2; tbl[0].c = 2; tbl[0].p = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
    tbl[1].r = 2; tbl[1].c = 3; tbl[1].p = '{1, 2, 3, 11, 12, 13, 21, 22, 23};
    tbl[2].r = 2; tbl[2].c = 4; tbl[2].p = '{2, 3, 4, 12, 13, 14, 22, 23, 24};
    tbl[3].r = 3; tbl[3].c = 2; tbl[3].p = '{10, 11, 12, 20, 21, 22, 30, 31, 32};
    tbl[4].r = 3; tbl[4].c = 3; tbl[4].p = '{11, 12, 13, 21, 22, 23, 31, 32, 33};
    tbl[5].r = 3; tbl[5].c = 4; tbl[5].p = '{12, 13, 14, 22, 23, 24, 32, 33, 34};
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 0;

    // Reset state
    #3;
    chk("rst_win_valid", int'(win_valid), 0);
    for (int k = 0; k < 9; k++) chk($sformatf("rst_px%0d", k), int'(px[k]), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_row = 0;
    m_col = 0;

    // Continuous frame, first beat after reset carries sof
    clear_stats();
    frame(0, 1'b1, 1'b0);
    chk("frame_windows", win_cnt, 6);
    check_tbl(0);

    // Same frame with an idle cycle after every beat
    clear_stats();
    frame(0, 1'b1, 1'b1);
    chk("gapped_windows", win_cnt, 6);
    check_tbl(0);

    // Two back-to-back frames
    clear_stats();
    frame(0, 1'b1, 1'b0);
    frame(0, 1'b1, 1'b0);
    chk("b2b_windows", win_cnt, 12);
    check_tbl(6);

    // Mid-frame sof at beat (2,3)
    clear_stats();
    for (int i = 0; i < 13; i++) step(1'b1, i == 0, 10 * (i / W) + i % W);
    clear_stats();
    frame(100, 1'b1, 1'b0);
    chk("midsof_first_win_beat", first_win_beat, 12);
    chk("midsof_windows", win_cnt, 6);

    // Asynchronous reset before beat (3,1)
    clear_stats();
    for (int i = 0; i < 16; i++) step(1'b1, i == 0, 10 * (i / W) + i % W);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_win_valid", int'(win_valid), 0);
    for (int k = 0; k < 9; k++) chk($sformatf("midrst_px%0d", k), int'(px[k]), 0);
    #1;
    rst = 1'b0;
    m_row = 0;
    m_col = 0;
    clear_stats();
    frame(50, 1'b0, 1'b0);
    chk("midrst_first_win_beat", first_win_beat, 12);
    chk("midrst_windows", win_cnt, 6);

    // Frame wrap without sof on the second frame
    clear_stats();
    frame(0, 1'b1, 1'b0);
    frame(200, 1'b0, 1'b0);
    chk("wrap_windows", win_cnt, 12);

    // Random traffic with occasional sof
    clear_stats();
    for (int i = 0; i < 400; i++) begin
      bit v;
      bit s;
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 24) == 0);
      step(v, s, int'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
